// File: rtl/imem_dict_decomp.sv
// Dictionary-based instruction decompressor between an I-cache refill port and imem.
// 16-bit codewords expand via a 256-entry dictionary or an escape fetch from an overflow region.
module imem_dict_decomp #(
  parameter int unsigned DICT_DEPTH = 256,
  parameter logic [31:0] CMP_BASE   = 32'h0000_0000,
  parameter logic [31:0] OVF_BASE   = 32'h0000_8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic [31:0] req_rdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        dict_we,
  input  logic [7:0]  dict_waddr,
  input  logic [31:0] dict_wdata,
  output logic        dbg_buf_hit,
  output logic        dbg_escape
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] FETCH_CW  = 3'd1;
  localparam logic [2:0] DECODE    = 3'd2;
  localparam logic [2:0] FETCH_OVF = 3'd3;
  localparam logic [2:0] RESP      = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] word_q;
  logic        slot_q;
  logic        esc_q;
  logic [31:0] ovf_data_q;
  logic [31:0] rdata_q;
  logic        buf_valid;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;

  logic [31:0] dict_mem [DICT_DEPTH];
  logic [31:0] dict_rdata;

  logic [31:0] w_in;
  logic        hit;
  logic [15:0] cw;
  logic [31:0] ovf_addr;
  logic [31:0] result;
  logic        unused;

  assign unused   = ^req_addr[1:0];
  // Two codewords per imem word, so the word index is the instruction index halved.
  assign w_in     = CMP_BASE + {1'b0, req_addr[31:3], 2'b00};
  assign hit      = buf_valid && (w_in == buf_addr);
  assign cw       = slot_q ? buf_data[31:16] : buf_data[15:0];
  assign ovf_addr = OVF_BASE + {15'b0, cw[14:0], 2'b00};
  assign result   = esc_q ? ovf_data_q : dict_rdata;

  // Read-before-write: a same-index write in the read cycle returns the old entry.
  always_ff @(posedge clk) begin
    if (dict_we) dict_mem[dict_waddr] <= dict_wdata;
    if (state_q == DECODE) dict_rdata <= dict_mem[cw[7:0]];
  end

  always_comb begin
    state_d     = state_q;
    mem_valid   = 1'b0;
    mem_addr    = 32'h0;
    req_ready   = 1'b0;
    req_rdata   = rdata_q;
    dbg_buf_hit = 1'b0;
    dbg_escape  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            dbg_buf_hit = 1'b1;
            state_d     = DECODE;
          end else begin
            state_d = FETCH_CW;
          end
        end
      end
      FETCH_CW: begin
        mem_valid = 1'b1;
        mem_addr  = word_q;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        if (!cw[15]) begin
          dbg_escape = 1'b1;
          state_d    = FETCH_OVF;
        end else begin
          state_d = RESP;
        end
      end
      FETCH_OVF: begin
        mem_valid = 1'b1;
        mem_addr  = ovf_addr;
        if (mem_ready) state_d = RESP;
      end
      RESP: begin
        // A withdrawn request simply drops the result.
        if (req_valid) begin
          req_ready = 1'b1;
          req_rdata = result;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= 32'h0;
      slot_q     <= 1'b0;
      esc_q      <= 1'b0;
      ovf_data_q <= 32'h0;
      rdata_q    <= 32'h0;
      buf_valid  <= 1'b0;
      buf_addr   <= 32'h0;
      buf_data   <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        word_q <= w_in;
        slot_q <= req_addr[2];
      end
      if (state_q == FETCH_CW && mem_ready) begin
        buf_valid <= 1'b1;
        buf_addr  <= word_q;
        buf_data  <= mem_rdata;
      end
      if (state_q == DECODE) esc_q <= !cw[15];
      if (state_q == FETCH_OVF && mem_ready) ovf_data_q <= mem_rdata;
      if (state_q == RESP && req_valid) rdata_q <= result;
    end
  end

endmodule

// File: tb/tb_imem_dict_decomp.sv
// Directed bench for imem_dict_decomp: imem responder with programmable wait states,
// one task per scenario with inline expected values.
module tb_imem_dict_decomp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_rdata;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        dict_we = 1'b0;
  logic [7:0]  dict_waddr = 8'h0;
  logic [31:0] dict_wdata = 32'h0;
  logic        dbg_buf_hit;
  logic        dbg_escape;

  int total = 0;
  int bad = 0;

  int mem_delay = 0;
  int wait_cnt = 0;
  int hit_cnt = 0;
  int esc_cnt = 0;
  logic [31:0] mem_log[$];
  logic [31:0] imem [logic [31:0]];

  imem_dict_decomp dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_rdata   (req_rdata),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .dict_we     (dict_we),
    .dict_waddr  (dict_waddr),
    .dict_wdata  (dict_wdata),
    .dbg_buf_hit (dbg_buf_hit),
    .dbg_escape  (dbg_escape)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_read(input logic [31:0] a);
    if (imem.exists(a)) return imem[a];
    return 32'h0;
  endfunction

  // imem responder: completes after mem_delay withheld cycles; logs completed reads.
  always @(negedge clk) begin
    mem_ready = 1'b0;
    if (dbg_buf_hit) hit_cnt++;
    if (dbg_escape) esc_cnt++;
    if (mem_valid) begin
      if (wait_cnt >= mem_delay) begin
        mem_ready = 1'b1;
        mem_rdata = imem_read(mem_addr);
        mem_log.push_back(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Called at posedge+1; returns data and cycles until req_ready is seen.
  task automatic do_req(input logic [31:0] a, output logic [31:0] d, output int lat);
    req_addr  = a;
    req_valid = 1'b1;
    d         = 32'hxxxx_xxxx;
    lat       = 0;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (req_ready) begin
        d = req_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic dict_write(input logic [7:0] idx, input logic [31:0] data);
    dict_we = 1'b1; dict_waddr = idx; dict_wdata = data;
    @(posedge clk); #1;
    dict_we = 1'b0;
  endtask

  task automatic clear_counts();
    mem_log.delete();
    hit_cnt = 0;
    esc_cnt = 0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid got=%b want=0", mem_valid); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
    total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", req_rdata); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    total++; if ({dbg_buf_hit, dbg_escape} !== 2'b00) begin
      bad++; $display("FAIL reset_dbg got=%b want=00", {dbg_buf_hit, dbg_escape});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    dict_write(8'h12, 32'h0000_0013);
    dict_write(8'h13, 32'h00A0_0093);
  endtask

  task automatic test_miss_dict();
    logic [31:0] d; int lat;
    clear_counts();
    do_req(32'h0, d, lat);
    total++; if (d !== 32'h00A0_0093) begin bad++; $display("FAIL miss_rdata got=%h want=00a00093", d); end
    total++; if (lat != 3) begin bad++; $display("FAIL miss_latency got=%0d want=3", lat); end
    total++; if (mem_log.size() != 1) begin bad++; $display("FAIL miss_reads got=%0d want=1", mem_log.size()); end
    total++; if (mem_log[0] !== 32'h0) begin bad++; $display("FAIL miss_addr got=%h want=0", mem_log[0]); end
  endtask

  task automatic test_buf_hit();
    logic [31:0] d; int lat;
    clear_counts();
    do_req(32'h4, d, lat);
    total++; if (d !== 32'h0000_0013) begin bad++; $display("FAIL hit_rdata got=%h want=00000013", d); end
    total++; if (lat != 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", lat); end
    total++; if (mem_log.size() != 0) begin bad++; $display("FAIL hit_reads got=%0d want=0", mem_log.size()); end
    total++; if (hit_cnt != 1) begin bad++; $display("FAIL hit_pulse got=%0d want=1", hit_cnt); end
  endtask

  task automatic test_escape();
    logic [31:0] d; int lat;
    clear_counts();
    do_req(32'h8, d, lat);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL esc_rdata got=%h want=deadbeef", d); end
    total++; if (lat != 4) begin bad++; $display("FAIL esc_latency got=%0d want=4", lat); end
    total++; if (mem_log.size() != 2) begin bad++; $display("FAIL esc_reads got=%0d want=2", mem_log.size()); end
    total++; if (mem_log[0] !== 32'h4) begin bad++; $display("FAIL esc_addr0 got=%h want=4", mem_log[0]); end
    total++; if (mem_log[1] !== 32'h800C) begin bad++; $display("FAIL esc_addr1 got=%h want=800c", mem_log[1]); end
    total++; if (esc_cnt != 1) begin bad++; $display("FAIL esc_pulse got=%0d want=1", esc_cnt); end
    total++; if (hit_cnt != 0) begin bad++; $display("FAIL esc_hit got=%0d want=0", hit_cnt); end
  endtask

  task automatic test_dict_rw();
    logic [31:0] d; int lat;
    clear_counts();
    fork
      do_req(32'h4, d, lat);
      begin
        // Acceptance at cycle 0, fetch completes in cycle 1, DECODE in cycle 2.
        @(posedge clk); @(posedge clk); #1;
        dict_we = 1'b1; dict_waddr = 8'h12; dict_wdata = 32'h1111_1111;
        @(posedge clk); #1;
        dict_we = 1'b0;
      end
    join
    total++; if (d !== 32'h0000_0013) begin bad++; $display("FAIL rw_old_data got=%h want=00000013", d); end
    do_req(32'h4, d, lat);
    total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL rw_new_data got=%h want=11111111", d); end
    total++; if (lat != 2) begin bad++; $display("FAIL rw_hit_latency got=%0d want=2", lat); end
  endtask

  task automatic test_stall_reset();
    logic [31:0] d; int lat;
    clear_counts();
    mem_delay = 5;
    req_addr = 32'h8; req_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      total++; if (mem_valid !== 1'b1 || mem_addr !== 32'h4) begin
        bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/00000004", k, mem_valid, mem_addr);
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    total++; if (mem_valid !== 1'b1 || mem_addr !== 32'h800C) begin
      bad++; $display("FAIL stall_ovf got=%b/%h want=1/0000800c", mem_valid, mem_addr);
    end
    reset = 1'b1;
    #1;
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_ovf_valid got=%b want=0", mem_valid); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_ovf_addr got=%h want=0", mem_addr); end
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    mem_delay = 0;
    clear_counts();
    // Buffer must have been invalidated by reset: word 0x4 needs a fresh read.
    do_req(32'h8, d, lat);
    total++; if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rst_esc_rdata got=%h want=deadbeef", d); end
    total++; if (mem_log.size() != 2 || mem_log[0] !== 32'h4) begin
      bad++; $display("FAIL rst_buf_cleared reads=%0d addr=%h want=2/00000004", mem_log.size(), mem_log[0]);
    end
    clear_counts();
    do_req(32'h4, d, lat);
    total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL rst_refetch_rdata got=%h want=11111111", d); end
    total++; if (mem_log.size() != 1 || mem_log[0] !== 32'h0) begin
      bad++; $display("FAIL rst_refetch reads=%0d addr=%h want=1/00000000", mem_log.size(), mem_log[0]);
    end
  endtask

  task automatic test_withdraw();
    logic [31:0] d; int lat;
    logic seen_ready;
    clear_counts();
    mem_delay = 3;
    seen_ready = 1'b0;
    req_addr = 32'h8; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      seen_ready = seen_ready | req_ready;
    end
    total++; if (seen_ready !== 1'b0) begin bad++; $display("FAIL wd_no_ready got=%b want=0", seen_ready); end
    total++; if (mem_log.size() != 2 || mem_log[0] !== 32'h4) begin
      bad++; $display("FAIL wd_fetch_done reads=%0d addr=%h want=2/00000004", mem_log.size(), mem_log[0]);
    end
    total++; if (req_rdata !== 32'h1111_1111) begin bad++; $display("FAIL wd_rdata_hold got=%h want=11111111", req_rdata); end
    mem_delay = 0;
    clear_counts();
    do_req(32'h4, d, lat);
    total++; if (d !== 32'h1111_1111) begin bad++; $display("FAIL wd_next_rdata got=%h want=11111111", d); end
    total++; if (lat != 3) begin bad++; $display("FAIL wd_next_latency got=%0d want=3", lat); end
  endtask

  initial begin
    imem[32'h0]    = 32'h8012_8013;
    imem[32'h4]    = 32'h0000_0003;
    imem[32'h800C] = 32'hDEAD_BEEF;
    test_reset();
    test_miss_dict();
    test_buf_hit();
    test_escape();
    test_dict_rw();
    test_stall_reset();
    test_withdraw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_dict_decomp.md
Name: imem_dict_decomp

Overview:
- Dictionary-based instruction decompressor between the instruction cache refill port (mem_req_*) and the instruction memory.
- Translates each uncompressed instruction word request into 16-bit codeword fetches from a compressed image.
- Expands each codeword through a 256-entry dictionary, or through an escape fetch from an uncompressed overflow region.
- Keeps a one-word codeword buffer so that sibling instructions sharing one imem word need a single memory read.

Parameters:
DICT_DEPTH  256  dictionary entries; index width is log2(DICT_DEPTH)=8
CMP_BASE  32'h0000_0000  byte base of the compressed codeword image in imem
OVF_BASE  32'h0000_8000  byte base of the uncompressed overflow region in imem

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  cache refill request; held until req_ready
req_ready  out  1  one-cycle pulse; req_rdata valid in the same cycle
req_addr  in  32  uncompressed byte address; bits [1:0] ignored
req_rdata  out  32  decompressed instruction
mem_valid  out  1  imem request; held until mem_ready
mem_ready  in  1  imem completion; mem_rdata valid in the same cycle
mem_addr  out  32  imem byte address, word aligned
mem_rdata  in  32  imem read data
dict_we  in  1  dictionary write enable
dict_waddr  in  8  dictionary write index
dict_wdata  in  32  dictionary write data
dbg_buf_hit  out  1  one-cycle pulse: request served from the codeword buffer
dbg_escape  out  1  one-cycle pulse: overflow fetch issued

Behaviour:
- Address map:
  - W = CMP_BASE + {req_addr[31:3], 2'b00}.
  - slot = req_addr[2]: 0 selects mem word [15:0]; 1 selects [31:16].
- Codeword h:
  - h[15]=1: instruction = dict[h[7:0]]; h[14:8] is ignored.
  - h[15]=0: instruction = imem word at OVF_BASE + {h[14:0], 2'b00}.
- Dictionary:
  - Synchronous-read RAM with a one-cycle read.
  - Write port is usable in any state.
  - A same-index read and write in the same cycle returns the old data.
  - Dictionary contents are not reset.
- Codeword buffer: buf_valid, buf_addr (32), buf_data (32).
  - Loaded only by codeword fetches; overflow fetches never load it.
- FSM states: IDLE, FETCH_CW, DECODE, FETCH_OVF, RESP.
  - IDLE, req_valid=1: latch the address and slot.
    - If buf_valid and W==buf_addr: pulse dbg_buf_hit and go to DECODE.
    - Otherwise go to FETCH_CW.
  - FETCH_CW: mem_valid=1, mem_addr=W. On mem_ready, load the buffer (buf_valid=1) and go to DECODE.
  - DECODE: issue the dictionary read.
    - Escape codeword: pulse dbg_escape and go to FETCH_OVF.
    - Otherwise go to RESP.
  - FETCH_OVF: mem_valid=1, mem_addr=overflow address. On mem_ready, latch mem_rdata and go to RESP.
  - RESP:
    - If req_valid=1: req_ready=1, req_rdata=result, go to IDLE.
    - If req_valid=0 (request withdrawn): no pulse, result discarded, go to IDLE.
- Latency from the acceptance cycle N:
  - Buffer hit with dictionary entry: req_ready at N+2.
  - Miss with dictionary entry: mem_valid from N+1; mem_ready at M gives req_ready at M+2.
  - Escape: mem_ready of the overflow fetch at K gives req_ready at K+1.
- Downstream: mem_valid and mem_addr stay stable until mem_ready, even if req_valid drops. Only one outstanding imem transaction at a time.
- req_rdata holds its last value between responses.
- Reset (asynchronous, any state):
  - Outputs: mem_valid=0, req_ready=0, req_rdata=0, mem_addr=0, dbg_* outputs=0.
  - Internal: state=IDLE, buf_valid=0.
  - Any in-flight transaction is abandoned.
- A mem_ready outside FETCH_CW or FETCH_OVF is ignored.

Test Plan:
1. Setup: dict[0x12]=0x00000013, dict[0x13]=0x00A00093, imem[0x0]=0x80128013. Request req_addr=0x0 -> one imem read at 0x0; req_rdata=0x00A00093 with req_ready two cycles after mem_ready.
2. Directly after test 1, request req_addr=0x4 -> no mem_valid; dbg_buf_hit pulses; req_rdata=0x00000013 at N+2.
3. Setup: imem[0x4]=0x00000003, imem[0x800C]=0xDEADBEEF. Request req_addr=0x8 -> imem reads at 0x4 then 0x800C; dbg_escape pulses once; req_rdata=0xDEADBEEF.
4. During DECODE for index 0x12, drive dict_we with 0x12 / 0x11111111 -> response is 0x00000013; a following request gets 0x11111111.
5. mem_ready withheld 5 cycles -> mem_valid and mem_addr stable throughout. Assert reset during FETCH_OVF -> mem_valid=0 immediately. A later request to 0x4 refetches imem[0x0].
6. req_valid dropped while in FETCH_CW -> the imem transaction still completes; no req_ready pulse; FSM returns to IDLE and accepts the next request normally.
